// File: rtl/decode_hazard_controller_if.sv
// rtl/decode_hazard_controller_if.sv - decode-side signal bundle for the hazard controller
//
// Purpose: groups the decode-stage inputs and the hazard/flush outputs of
//          decode_hazard_controller into one interface.
// Ports (signals):
//   issue_valid_IN, srcA_IN, srcA_use_IN, srcB_IN, srcB_use_IN,
//   wren_IN, writeAd_IN, PC_load_IN             -> into the controller
//   stall_OUT, bubble_OUT, flush_OUT, state_OUT,
//   busy_OUT[7:0], stall_count_OUT              <- from the controller
// Modports: master = decode/pipeline side, slave = controller side.
interface decode_hazard_controller_if #(
    parameter int STALL_CNT_W = 8
);
    logic                   issue_valid_IN;
    logic [2:0]             srcA_IN;
    logic                   srcA_use_IN;
    logic [2:0]             srcB_IN;
    logic                   srcB_use_IN;
    logic                   wren_IN;
    logic [2:0]             writeAd_IN;
    logic                   PC_load_IN;

    logic                   stall_OUT;
    logic                   bubble_OUT;
    logic                   flush_OUT;
    logic                   state_OUT;
    logic [7:0]             busy_OUT;
    logic [STALL_CNT_W-1:0] stall_count_OUT;

    modport master (
        output issue_valid_IN, srcA_IN, srcA_use_IN, srcB_IN, srcB_use_IN,
               wren_IN, writeAd_IN, PC_load_IN,
        input  stall_OUT, bubble_OUT, flush_OUT, state_OUT, busy_OUT,
               stall_count_OUT
    );

    modport slave (
        input  issue_valid_IN, srcA_IN, srcA_use_IN, srcB_IN, srcB_use_IN,
               wren_IN, writeAd_IN, PC_load_IN,
        output stall_OUT, bubble_OUT, flush_OUT, state_OUT, busy_OUT,
               stall_count_OUT
    );
endinterface

// File: rtl/decode_hazard_controller.sv
// rtl/decode_hazard_controller.sv - decode-stage RAW/WAW hazard scoreboard and branch flush sequencer
//
// Purpose: per-register countdown scoreboard of in-flight writes; raises a
//          combinational stall/bubble on RAW/WAW hazards against the
//          instruction in decode, and runs a registered flush sequence after
//          a taken branch (PC load).
// Ports:
//   CLK   clock
//   RST   synchronous active-high reset
//   bus   decode_hazard_controller_if.slave (decode inputs, hazard outputs)
// Optional build macro: DECODE_HAZARD_FORWARD_EN
//   defined   -> RAW only stalls on a producer issued the previous cycle
//   undefined -> RAW stalls on any pending write to a source register
module decode_hazard_controller #(
    parameter int WB_LATENCY   = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int STALL_CNT_W  = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    decode_hazard_controller_if.slave    bus
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [2:0] WB_LAT_LD = 3'(WB_LATENCY);
    localparam logic [2:0] FLUSH_LD  = 3'(FLUSH_CYCLES);
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    state_t                   state_q, state_d;
    logic [2:0]               flush_cnt_q, flush_cnt_d;
    logic [7:0][2:0]          cnt_q, cnt_d;
    logic [STALL_CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic [7:0]               busy;
    logic                     raw, waw, stall, accept, in_run;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            busy[i] = (cnt_q[i] != 3'd0);
        end
    end

    assign in_run = (state_q == ST_RUN);

`ifdef DECODE_HAZARD_FORWARD_EN
    // Forwarding covers every producer except one issued last cycle, whose
    // counter still holds the freshly loaded latency value.
    assign raw = (bus.srcA_use_IN & (cnt_q[bus.srcA_IN] == WB_LAT_LD)) |
                 (bus.srcB_use_IN & (cnt_q[bus.srcB_IN] == WB_LAT_LD));
`else
    assign raw = (bus.srcA_use_IN & busy[bus.srcA_IN]) |
                 (bus.srcB_use_IN & busy[bus.srcB_IN]);
`endif

    assign waw = bus.wren_IN & busy[bus.writeAd_IN];

    // A PC load wins over any hazard: the decode instruction is discarded anyway.
    assign stall  = bus.issue_valid_IN & in_run & ~bus.PC_load_IN & (raw | waw);
    assign accept = bus.issue_valid_IN & in_run & ~bus.PC_load_IN & ~stall;

    // Scoreboard next state: decrement all pending entries, then let an
    // accepted write reload its destination entry.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = (cnt_q[i] != 3'd0) ? (cnt_q[i] - 3'd1) : 3'd0;
        end
        if (accept && bus.wren_IN) begin
            cnt_d[bus.writeAd_IN] = WB_LAT_LD;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_ONE;
        end
    end

    // Flush FSM: the counter holds the number of FLUSH cycles remaining,
    // including the current one; a new PC load restarts the sequence.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (bus.PC_load_IN) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_LD;
                end
            end
            ST_FLUSH: begin
                if (bus.PC_load_IN) begin
                    flush_cnt_d = FLUSH_LD;
                end else if (flush_cnt_q <= 3'd1) begin
                    state_d     = ST_RUN;
                    flush_cnt_d = 3'd0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            default: begin
                state_d     = ST_RUN;
                flush_cnt_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 3'd0;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_OUT       = stall;
    assign bus.flush_OUT       = (state_q == ST_FLUSH);
    assign bus.bubble_OUT      = stall | (state_q == ST_FLUSH) | (in_run & bus.PC_load_IN);
    assign bus.state_OUT       = state_q;
    assign bus.busy_OUT        = busy;
    assign bus.stall_count_OUT = stall_cnt_q;

endmodule

// File: tb/tb_decode_hazard_controller.sv
// tb/tb_decode_hazard_controller.sv - directed self-checking bench for decode_hazard_controller
module tb_decode_hazard_controller;

    logic CLK;
    logic RST;

    decode_hazard_controller_if #(.STALL_CNT_W(8)) bus ();

    decode_hazard_controller #(
        .WB_LATENCY  (3),
        .FLUSH_CYCLES(2),
        .STALL_CNT_W (8)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cmp_cnt = 0;
    int err_cnt = 0;

`ifdef DECODE_HAZARD_FORWARD_EN
    localparam logic RAW_C23   = 1'b0;
    localparam int   RAW_STALL = 1;
`else
    localparam logic RAW_C23   = 1'b1;
    localparam int   RAW_STALL = 3;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid_IN = 1'b0;
        bus.srcA_IN        = 3'd0;
        bus.srcA_use_IN    = 1'b0;
        bus.srcB_IN        = 3'd0;
        bus.srcB_use_IN    = 1'b0;
        bus.wren_IN        = 1'b0;
        bus.writeAd_IN     = 3'd0;
        bus.PC_load_IN     = 1'b0;
    endtask

    initial begin
        // Reset with hostile inputs held
        idle();
        RST = 1'b1;
        bus.PC_load_IN     = 1'b1;
        bus.issue_valid_IN = 1'b1;
        bus.wren_IN        = 1'b1;
        bus.writeAd_IN     = 3'd3;
        tick();
        tick();
        RST = 1'b0;
        idle();
        #1;
        chk("rst_stall",  32'(bus.stall_OUT),       32'd0);
        chk("rst_bubble", 32'(bus.bubble_OUT),      32'd0);
        chk("rst_flush",  32'(bus.flush_OUT),       32'd0);
        chk("rst_state",  32'(bus.state_OUT),       32'd0);
        chk("rst_busy",   32'(bus.busy_OUT),        32'd0);
        chk("rst_scnt",   32'(bus.stall_count_OUT), 32'd0);

        // RAW: write r3 in cycle 0, read r3 from cycle 1
        bus.issue_valid_IN = 1'b1;
        bus.wren_IN        = 1'b1;
        bus.writeAd_IN     = 3'd3;
        #1;
        chk("raw_c0_stall", 32'(bus.stall_OUT), 32'd0);
        tick();
        bus.wren_IN     = 1'b0;
        bus.srcA_IN     = 3'd3;
        bus.srcA_use_IN = 1'b1;
        #1;
        chk("raw_c1_busy",   32'(bus.busy_OUT),   32'h08);
        chk("raw_c1_stall",  32'(bus.stall_OUT),  32'd1);
        chk("raw_c1_bubble", 32'(bus.bubble_OUT), 32'd1);
        tick();
        chk("raw_c2_stall", 32'(bus.stall_OUT), 32'(RAW_C23));
        tick();
        chk("raw_c3_stall", 32'(bus.stall_OUT), 32'(RAW_C23));
        tick();
        chk("raw_c4_stall", 32'(bus.stall_OUT),       32'd0);
        chk("raw_c4_busy",  32'(bus.busy_OUT),        32'd0);
        chk("raw_c4_scnt",  32'(bus.stall_count_OUT), 32'(RAW_STALL));
        tick();

        // Flush: PC load, two flush cycles, back to RUN
        idle();
        bus.PC_load_IN = 1'b1;
        #1;
        chk("fl_c5_bubble", 32'(bus.bubble_OUT), 32'd1);
        chk("fl_c5_stall",  32'(bus.stall_OUT),  32'd0);
        chk("fl_c5_flush",  32'(bus.flush_OUT),  32'd0);
        tick();
        bus.PC_load_IN     = 1'b0;
        bus.issue_valid_IN = 1'b1;
        bus.wren_IN        = 1'b1;
        bus.writeAd_IN     = 3'd6;
        #1;
        chk("fl_c6_flush",  32'(bus.flush_OUT),  32'd1);
        chk("fl_c6_state",  32'(bus.state_OUT),  32'd1);
        chk("fl_c6_bubble", 32'(bus.bubble_OUT), 32'd1);
        tick();
        chk("fl_c7_flush", 32'(bus.flush_OUT), 32'd1);
        tick();
        idle();
        #1;
        chk("fl_c8_state", 32'(bus.state_OUT), 32'd0);
        chk("fl_c8_flush", 32'(bus.flush_OUT), 32'd0);
        chk("fl_c8_busy",  32'(bus.busy_OUT),  32'd0);

        // Flush extended by a second PC load in its last cycle
        bus.PC_load_IN = 1'b1;
        tick();
        bus.PC_load_IN = 1'b0;
        tick();
        bus.PC_load_IN = 1'b1;
        #1;
        chk("ext_e2_flush", 32'(bus.flush_OUT), 32'd1);
        tick();
        bus.PC_load_IN = 1'b0;
        tick();
        chk("ext_e4_flush", 32'(bus.flush_OUT), 32'd1);
        chk("ext_e4_state", 32'(bus.state_OUT), 32'd1);
        tick();
        chk("ext_e5_state", 32'(bus.state_OUT), 32'd0);
        chk("ext_e5_flush", 32'(bus.flush_OUT), 32'd0);

        // Branch during a hazard: PC load wins
        bus.issue_valid_IN = 1'b1;
        bus.wren_IN        = 1'b1;
        bus.writeAd_IN     = 3'd2;
        tick();
        bus.wren_IN     = 1'b0;
        bus.srcB_IN     = 3'd2;
        bus.srcB_use_IN = 1'b1;
        bus.PC_load_IN  = 1'b1;
        #1;
        chk("br_b1_busy",   32'(bus.busy_OUT),   32'h04);
        chk("br_b1_stall",  32'(bus.stall_OUT),  32'd0);
        chk("br_b1_bubble", 32'(bus.bubble_OUT), 32'd1);
        tick();
        idle();
        #1;
        chk("br_b2_flush", 32'(bus.flush_OUT), 32'd1);
        chk("br_b2_busy",  32'(bus.busy_OUT),  32'h04);
        tick();
        chk("br_b3_busy", 32'(bus.busy_OUT), 32'h04);
        tick();
        chk("br_b4_busy",  32'(bus.busy_OUT),        32'd0);
        chk("br_b4_state", 32'(bus.state_OUT),       32'd0);
        chk("br_b4_scnt",  32'(bus.stall_count_OUT), 32'(RAW_STALL));

        // WAW and reload once the entry reaches zero
        bus.issue_valid_IN = 1'b1;
        bus.wren_IN        = 1'b1;
        bus.writeAd_IN     = 3'd5;
        tick();
        chk("waw_r1_stall", 32'(bus.stall_OUT), 32'd1);
        chk("waw_r1_busy",  32'(bus.busy_OUT),  32'h20);
        tick();
        tick();
        tick();
        chk("rl_r4_stall", 32'(bus.stall_OUT), 32'd0);
        chk("rl_r4_busy",  32'(bus.busy_OUT),  32'd0);
        tick();
        idle();
        #1;
        chk("rl_r5_busy", 32'(bus.busy_OUT), 32'h20);
        tick();
        tick();
        chk("rl_r7_busy", 32'(bus.busy_OUT), 32'h20);
        tick();
        chk("rl_r8_busy", 32'(bus.busy_OUT),        32'd0);
        chk("rl_r8_scnt", 32'(bus.stall_count_OUT), 32'(RAW_STALL + 3));

        // Saturation: self-dependent write to r1 stalls 3 of every 4 cycles
        bus.issue_valid_IN = 1'b1;
        bus.wren_IN        = 1'b1;
        bus.writeAd_IN     = 3'd1;
        bus.srcA_IN        = 3'd1;
        bus.srcA_use_IN    = 1'b1;
        repeat (8) tick();
        chk("sat_part_scnt", 32'(bus.stall_count_OUT), 32'(RAW_STALL + 3 + 6));
        repeat (392) tick();
        chk("sat_scnt", 32'(bus.stall_count_OUT), 32'd255);
        repeat (20) tick();
        chk("sat_hold_scnt", 32'(bus.stall_count_OUT), 32'd255);

        // Reset in the middle of a flush
        idle();
        bus.PC_load_IN = 1'b1;
        tick();
        bus.PC_load_IN = 1'b0;
        #1;
        chk("mid_flush_state", 32'(bus.state_OUT), 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        chk("rst2_state", 32'(bus.state_OUT),       32'd0);
        chk("rst2_flush", 32'(bus.flush_OUT),       32'd0);
        chk("rst2_busy",  32'(bus.busy_OUT),        32'd0);
        chk("rst2_scnt",  32'(bus.stall_count_OUT), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
